ioctl_text_feeder: RTL and testbench
====================================

Name: ioctl_text_feeder

Overview:
- Consumer end of the HPS ioctl download path for the "Load Ascii" TXT file (menu index 0).
- Accepts bytes written by hps_io and buffers them in a FIFO, applying back-pressure through ioctl_wait.
- Converts line endings to UK101 conventions, then presents one character at a time on a valid/ready port to the ACIA receive multiplexer in uk101.
- Paces output with programmable inter-character and end-of-line gaps so BASIC/monitor input keeps up.

Parameters:
- DEPTH, 16: FIFO depth in bytes, power of two, ≥4.
- CHAR_GAP, 48000: idle clk cycles after each character (1 ms at 48 MHz).
- LINE_GAP, 4800000: idle clk cycles after a CR (100 ms at 48 MHz).
- FILE_INDEX, 0: ioctl_index[5:0] value that selects this block.

Ports:
- clk  in  1  system clock (clk_sys, 48 MHz).
- n_reset  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download active, from hps_io.
- ioctl_index  in  8  file index, from hps_io.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  back-pressure to hps_io.
- rx_data  out  8  character to the ACIA receive path.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- busy  out  1  a file is in progress or still draining.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (n_reset=0, asynchronous): FIFO empty; state IDLE; gap counter 0; ioctl_wait=0, rx_valid=0, rx_data=0, busy=0, overflow=0; last_was_cr=0.
- Selection: sel = ioctl_download & (ioctl_index[5:0]==FILE_INDEX). Only bytes written while sel=1 are considered.
- Write filter, evaluated on each ioctl_wr while sel=1:
  - 0x0A after an accepted 0x0D (last_was_cr=1): dropped, nothing written.
  - Any other 0x0A: written as 0x0D.
  - All other bytes: written unchanged.
  - last_was_cr is updated from the byte's converted value; it is cleared on each rising edge of sel.
- FIFO:
  - Registered, synchronous, count width $clog2(DEPTH)+1.
  - Simultaneous push and pop in one cycle leaves the count unchanged.
  - A push while count==DEPTH is dropped and sets overflow, which stays set until reset or the next rising edge of sel.
  - Pointers wrap modulo DEPTH.
- ioctl_wait is registered: 1 when count ≥ DEPTH-2 in the previous cycle, otherwise 0. This leaves two slots of margin for hps_io latency.
- Output FSM:
  - IDLE: if FIFO is non-empty, pop, load rx_data, set rx_valid=1 on the next cycle, go to PRESENT.
  - PRESENT: hold rx_data and rx_valid stable until rx_ready=1. In the rx_ready cycle, drop rx_valid on the next edge. Load the counter with LINE_GAP-1 if rx_data==0x0D, else CHAR_GAP-1, and go to GAP.
  - GAP: decrement each cycle; at 0 go to IDLE. A gap of N means at least N+1 cycles between the handshake and the next rx_valid rise.
  - Counter width is $clog2(LINE_GAP+1).
- busy:
  - Set on the rising edge of sel.
  - Cleared when sel=0, the FIFO is empty and the state is IDLE.
  - Falling ioctl_download does not abort the transfer; the FIFO drains fully.
- Restart: a rising edge of sel while busy=1 flushes the FIFO, forces the state to IDLE, and clears rx_valid and the counter in the same cycle. The new file replaces the old one; no partial character is presented twice.
- Non-selected downloads (other index) leave all state untouched and keep ioctl_wait at 0.
- The FSM never presents while rx_valid is already high; the consumer sees at most one character per handshake.

Test Plan:
- Basic: download index 0 with "A\r\nB\n", rx_ready tied 1, CHAR_GAP=4, LINE_GAP=20 → rx sees 0x41, 0x0D, 0x42, 0x0D in that order. Spacing is ≥5 cycles after 0x41 and ≥21 cycles after each 0x0D; busy falls after the last handshake plus gap.
- Back-pressure: DEPTH=16, rx_ready=0, write 20 bytes that honour ioctl_wait → ioctl_wait rises once count reaches 14, no byte is lost, overflow=0. After rx_ready=1, all 20 bytes are delivered in order.
- Overflow: DEPTH=16, rx_ready=0, 18 writes ignoring ioctl_wait → 16 stored (FIFO holds 16 while FSM pending? first pop already taken, so 17 accepted), overflow=1, and it stays 1 until the next download starts.
- Stall: rx_ready held 0 for 100 cycles with rx_valid=1 → rx_data stays constant and rx_valid stays 1; a one-cycle rx_ready pulse completes exactly one transfer.
- Index filter: download index 1 of "XYZ" → no rx_valid, ioctl_wait=0, busy=0.
- Restart and reset: new index-0 download starts mid-drain → old bytes are flushed and the first character out is the new file's first byte. Asserting n_reset mid-PRESENT immediately gives rx_valid=0, busy=0, ioctl_wait=0.

Source files
------------

// File: rtl/ioctl_text_feeder.sv
// Buffers the ASCII text download from hps_io, rewrites line endings to bare CR,
// and feeds characters one at a time to the ACIA receive path with pacing gaps.
module ioctl_text_feeder #(
  parameter int DEPTH      = 16,
  parameter int CHAR_GAP   = 48000,
  parameter int LINE_GAP   = 4800000,
  parameter int FILE_INDEX = 0
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ioctl_download,
  input  logic [7:0] ioctl_index,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(LINE_GAP + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t          state, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic [7:0]      rx_data_d;
  logic            rx_valid_d;
  logic            sel, sel_q, sel_rise, last_was_cr;
  logic            wr_sel, drop_lf, push_req, full, push, push_drop, pop;
  logic [7:0]      wr_byte;
  logic            unused_idx;

  assign unused_idx = ^ioctl_index[7:6];
  assign sel        = ioctl_download & (ioctl_index[5:0] == 6'(FILE_INDEX));
  assign sel_rise   = sel & ~sel_q;

  // A new file flushes everything, so the CR history and fullness restart too.
  assign wr_sel    = ioctl_wr & sel;
  assign drop_lf   = wr_sel & (ioctl_dout == 8'h0A) & last_was_cr & ~sel_rise;
  assign wr_byte   = (ioctl_dout == 8'h0A) ? 8'h0D : ioctl_dout;
  assign push_req  = wr_sel & ~drop_lf;
  assign full      = ~sel_rise & (count == CW'(DEPTH));
  assign push      = push_req & ~full;
  assign push_drop = push_req & full;
  assign pop       = (state == IDLE) & (count != '0) & ~sel_rise;

  always_ff @(posedge clk) begin
    if (push) mem[sel_rise ? '0 : wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sel_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_was_cr <= 1'b0;
      overflow    <= 1'b0;
      ioctl_wait  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sel_q      <= sel;
      ioctl_wait <= sel & (count >= CW'(DEPTH - 2));
      if (sel_rise) begin
        wr_ptr   <= push ? AW'(1) : '0;
        rd_ptr   <= '0;
        count    <= push ? CW'(1) : '0;
        overflow <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        count  <= count + CW'(push) - CW'(pop);
        if (push_drop) overflow <= 1'b1;
      end
      if (wr_sel)        last_was_cr <= push_req & (wr_byte == 8'h0D);
      else if (sel_rise) last_was_cr <= 1'b0;
      if (sel_rise)                                     busy <= 1'b1;
      else if (!sel && count == '0 && state == IDLE)    busy <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state;
    rx_valid_d = rx_valid;
    rx_data_d  = rx_data;
    gap_d      = gap_cnt;
    if (sel_rise) begin
      state_d    = IDLE;
      rx_valid_d = 1'b0;
      gap_d      = '0;
    end else begin
      case (state)
        IDLE: if (count != '0) begin
          rx_data_d  = mem[rd_ptr];
          rx_valid_d = 1'b1;
          state_d    = PRESENT;
        end
        PRESENT: if (rx_ready) begin
          rx_valid_d = 1'b0;
          gap_d      = (rx_data == 8'h0D) ? GW'(LINE_GAP - 1) : GW'(CHAR_GAP - 1);
          state_d    = GAP;
        end
        GAP: begin
          if (gap_cnt == '0) state_d = IDLE;
          else               gap_d   = gap_cnt - GW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_d;
      rx_valid <= rx_valid_d;
      rx_data  <= rx_data_d;
      gap_cnt  <= gap_d;
    end
  end
endmodule

// File: tb/tb_ioctl_text_feeder.sv
// Randomised bench for ioctl_text_feeder: a queue-based reference model of the
// FIFO, line-ending filter and pacing rules is compared against the DUT each cycle.
module tb_ioctl_text_feeder;
  localparam int DEPTH = 16, CG = 4, LG = 20;
  typedef logic [7:0] u8;

  logic clk = 0, n_reset = 0, ioctl_download = 0, ioctl_wr = 0, rx_ready = 0;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0;
  logic ioctl_wait, rx_valid, busy, overflow;
  logic [7:0] rx_data;

  ioctl_text_feeder #(.DEPTH(DEPTH), .CHAR_GAP(CG), .LINE_GAP(LG), .FILE_INDEX(0)) dut (
    .clk(clk), .n_reset(n_reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0, fails = 0, cyc = 0;
  int ready_mode = 0;  // 0/1 constant, 2 random
  u8  hs_q[$];
  int hs_cyc[$], rise_cyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #2 rx_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : ready_mode[0];
  end

  // Reference model: FIFO contents as a queue, the presented character, and the
  // earliest cycle the next character may be taken after a handshake gap.
  u8 q[$];
  bit m_pres, m_wait, m_busy, m_ovf, m_lwc, m_selq, prev_valid;
  u8 m_data;
  int m_ready_at;

  always @(negedge clk) begin
    cyc++;
    if (!n_reset) begin
      chk("rst_valid", rx_valid, 0); chk("rst_data", rx_data, 0);
      chk("rst_wait", ioctl_wait, 0); chk("rst_busy", busy, 0); chk("rst_ovf", overflow, 0);
      q.delete(); m_pres = 0; m_data = 0; m_ready_at = 0;
      m_wait = 0; m_busy = 0; m_ovf = 0; m_lwc = 0; m_selq = 0;
    end else begin
      automatic bit sel  = ioctl_download && (ioctl_index[5:0] == 6'd0);
      automatic bit rise = sel && !m_selq;
      automatic int npre = q.size();
      automatic bit idle = !m_pres && cyc >= m_ready_at;
      automatic bit lwc  = rise ? 1'b0 : m_lwc;
      automatic bit nbusy = rise ? 1'b1 : ((!sel && npre == 0 && idle) ? 1'b0 : m_busy);
      chk("rx_valid", rx_valid, m_pres);
      chk("rx_data", rx_data, m_data);
      chk("ioctl_wait", ioctl_wait, m_wait);
      chk("busy", busy, m_busy);
      chk("overflow", overflow, m_ovf);
      if (rx_valid && !prev_valid) rise_cyc.push_back(cyc);
      if (rx_valid && rx_ready) begin hs_q.push_back(rx_data); hs_cyc.push_back(cyc); end
      m_wait = sel && npre >= DEPTH - 2;
      if (rise) begin
        q.delete(); m_pres = 0; m_ready_at = cyc + 1; m_ovf = 0;
      end else if (idle && npre > 0) begin
        m_data = q.pop_front(); m_pres = 1;
      end else if (m_pres && rx_ready) begin
        m_pres = 0;
        m_ready_at = cyc + ((m_data == 8'h0D) ? LG : CG) + 1;
      end
      if (ioctl_wr && sel) begin
        if (ioctl_dout == 8'h0A && lwc) m_lwc = 0;
        else begin
          automatic u8 cv = (ioctl_dout == 8'h0A) ? 8'h0D : ioctl_dout;
          if (!rise && npre == DEPTH) m_ovf = 1;
          else q.push_back(cv);
          m_lwc = (cv == 8'h0D);
        end
      end else if (rise) m_lwc = 0;
      m_busy = nbusy; m_selq = sel;
    end
    prev_valid = rx_valid;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dl(u8 idx);
    ioctl_index = idx; ioctl_download = 1;
    tick(1);
  endtask

  task automatic end_dl();
    ioctl_download = 0;
    tick(1);
  endtask

  bit saw_wait;
  task automatic send(u8 b, bit honour);
    if (honour) begin
      automatic int n = 0;
      while (ioctl_wait) begin
        saw_wait = 1;
        tick(1); n++;
        if (n == 30) ready_mode = 1;
        if (n > 2000) begin chk("wait_timeout", 1, 0); break; end
      end
    end
    ioctl_wr = 1; ioctl_dout = b;
    tick(1);
    ioctl_wr = 0;
  endtask

  task automatic wait_idle(int budget);
    automatic int n = 0;
    while (busy || rx_valid) begin
      tick(1); n++;
      if (n > budget) begin chk("idle_timeout", 1, 0); break; end
    end
  endtask

  initial begin
    int b, r0;
    u8 d;
    u8 basic[5] = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A};
    tick(3);
    n_reset = 1;
    tick(2);

    // Basic: "A\r\nB\n" with rx_ready held high
    ready_mode = 1;
    b = hs_q.size(); r0 = rise_cyc.size();
    start_dl(0);
    foreach (basic[i]) send(basic[i], 1);
    end_dl();
    wait_idle(500);
    chk("basic_n", hs_q.size() - b, 4);
    if (hs_q.size() - b == 4 && rise_cyc.size() - r0 == 4) begin
      chk("basic_c0", hs_q[b], 8'h41); chk("basic_c1", hs_q[b+1], 8'h0D);
      chk("basic_c2", hs_q[b+2], 8'h42); chk("basic_c3", hs_q[b+3], 8'h0D);
      chk("basic_gap0", rise_cyc[r0+1] - hs_cyc[b], CG + 2);
      chk("basic_gap1", rise_cyc[r0+2] - hs_cyc[b+1], LG + 2);
      chk("basic_gap2", rise_cyc[r0+3] - hs_cyc[b+2], CG + 2);
    end
    chk("basic_busy_end", busy, 0);

    // Back-pressure: 20 bytes honouring ioctl_wait, consumer stalled at first
    ready_mode = 0; saw_wait = 0;
    b = hs_q.size();
    start_dl(0);
    for (int i = 0; i < 20; i++) send(u8'($urandom_range(8'h20, 8'h7E)), 1);
    end_dl();
    ready_mode = 1;
    wait_idle(1000);
    chk("bp_saw_wait", saw_wait, 1);
    chk("bp_ovf", overflow, 0);
    chk("bp_n", hs_q.size() - b, 20);

    // Overflow: 18 back-to-back writes with the consumer stalled
    ready_mode = 0;
    start_dl(0);
    for (int i = 0; i < 18; i++) send(u8'(8'h61 + i), 0);
    end_dl();
    chk("ovf_set", overflow, 1);

    // Stall: data held for 100 cycles, then a single-cycle ready pulse
    d = rx_data;
    tick(100);
    chk("stall_valid", rx_valid, 1);
    chk("stall_data", rx_data, d);
    chk("stall_c0", d, 8'h61);
    b = hs_q.size();
    ready_mode = 1; tick(1); ready_mode = 0;
    tick(30);
    chk("pulse_one", hs_q.size() - b, 1);
    chk("pulse_next", rx_data, 8'h62);
    chk("ovf_sticky", overflow, 1);

    // Restart mid-drain: the new file's first byte comes out first
    start_dl(0);
    chk("restart_ovf", overflow, 0);
    b = hs_q.size();
    send(8'h51, 1); send(8'h52, 1);
    end_dl();
    ready_mode = 1;
    wait_idle(500);
    chk("restart_n", hs_q.size() - b, 2);
    if (hs_q.size() - b == 2) begin
      chk("restart_c0", hs_q[b], 8'h51); chk("restart_c1", hs_q[b+1], 8'h52);
    end

    // Index filter: another file index is ignored entirely
    r0 = rise_cyc.size();
    start_dl(1);
    send(8'h58, 0); send(8'h59, 0); send(8'h5A, 0);
    end_dl();
    tick(20);
    chk("idx_rises", rise_cyc.size() - r0, 0);
    chk("idx_busy", busy, 0);
    chk("idx_wait", ioctl_wait, 0);

    // Random downloads with mixed line endings and random consumer readiness
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      automatic int n = $urandom_range(5, 40);
      start_dl(0);
      for (int i = 0; i < n; i++) begin
        automatic int k = $urandom_range(0, 9);
        send((k == 0) ? 8'h0A : (k == 1) ? 8'h0D : u8'($urandom_range(8'h20, 8'h7E)), 1);
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 8));
      end
      end_dl();
      if (r % 2 == 0) wait_idle(4000);
      else tick($urandom_range(5, 60));
    end
    wait_idle(4000);

    // Reset asserted while a character is presented
    ready_mode = 0;
    start_dl(0);
    send(8'h5A, 0);
    end_dl();
    tick(3);
    chk("pre_rst_valid", rx_valid, 1);
    n_reset = 0;
    #1;
    chk("async_rst_valid", rx_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_wait", ioctl_wait, 0);
    tick(2);
    n_reset = 1;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
